// File: rtl/float_to_unsig_int.sv
// IEEE-754 single to unsigned 32-bit integer (fcvt.wu.s, round toward zero) with NV/NX flags.
// Result strobe rises 4 edges after acceptance; a low output_z_ack holds PUT_Z and its data.
module float_to_unsig_int (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] input_a,
   input  logic        input_a_stb,
   output logic        input_a_ack,
   output logic [31:0] output_z,
   output logic        output_z_stb,
   input  logic        output_z_ack,
   output logic        output_nv,
   output logic        output_nx
);

   typedef enum logic [2:0] {GET_A, UNPACK, SPECIAL, CONVERT, PUT_Z} state_t;

   state_t             state_q, state_d;
   logic [31:0]        a_q, a_d;
   logic               s_q, s_d;
   logic signed [9:0]  e_q, e_d;
   logic [23:0]        m_q, m_d;
   logic               e_max_q, e_max_d;
   logic               e_zero_q, e_zero_d;
   logic               f_nz_q, f_nz_d;
   logic               spec_q, spec_d;
   logic [31:0]        spec_z_q, spec_z_d;
   logic               spec_nv_q, spec_nv_d;
   logic               spec_nx_q, spec_nx_d;
   logic [31:0]        z_q, z_d;
   logic               nv_q, nv_d;
   logic               nx_q, nx_d;
   logic               stb_q, stb_d;

   logic [4:0]         lsh, rsh;
   logic [23:0]        rmask;

   // Only meaningful in CONVERT, where 0 <= e <= 31 is guaranteed.
   assign lsh   = e_q[4:0] - 5'd23;
   assign rsh   = 5'd23 - e_q[4:0];
   assign rmask = (24'd1 << rsh) - 24'd1;

   assign input_a_ack  = (state_q == GET_A) && !rst;
   assign output_z_stb = stb_q && !rst;
   assign output_z     = z_q;
   assign output_nv    = nv_q;
   assign output_nx    = nx_q;

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      s_d       = s_q;
      e_d       = e_q;
      m_d       = m_q;
      e_max_d   = e_max_q;
      e_zero_d  = e_zero_q;
      f_nz_d    = f_nz_q;
      spec_d    = spec_q;
      spec_z_d  = spec_z_q;
      spec_nv_d = spec_nv_q;
      spec_nx_d = spec_nx_q;
      z_d       = z_q;
      nv_d      = nv_q;
      nx_d      = nx_q;
      stb_d     = stb_q;
      case (state_q)
         GET_A: begin
            if (input_a_stb && input_a_ack) begin
               a_d     = input_a;
               state_d = UNPACK;
            end
         end
         UNPACK: begin
            s_d      = a_q[31];
            e_d      = $signed({2'b00, a_q[30:23]}) - 10'sd127;
            m_d      = {1'b1, a_q[22:0]};
            e_max_d  = &a_q[30:23];
            e_zero_d = ~|a_q[30:23];
            f_nz_d   = |a_q[22:0];
            state_d  = SPECIAL;
         end
         SPECIAL: begin
            spec_d    = 1'b1;
            spec_z_d  = 32'd0;
            spec_nv_d = 1'b0;
            spec_nx_d = 1'b0;
            if (e_max_q) begin
               spec_nv_d = 1'b1;
               spec_z_d  = (f_nz_q || !s_q) ? 32'hFFFF_FFFF : 32'd0;
            end else if (e_zero_q) begin
               spec_nx_d = f_nz_q;
            end else if (s_q) begin
               spec_nv_d = !e_q[9];
               spec_nx_d = e_q[9];
            end else if (e_q[9]) begin
               spec_nx_d = 1'b1;
            end else if (e_q >= 10'sd32) begin
               spec_z_d  = 32'hFFFF_FFFF;
               spec_nv_d = 1'b1;
            end else begin
               spec_d    = 1'b0;
            end
            state_d = CONVERT;
         end
         CONVERT: begin
            if (spec_q) begin
               z_d  = spec_z_q;
               nv_d = spec_nv_q;
               nx_d = spec_nx_q;
            end else if (e_q[4:0] >= 5'd23) begin
               z_d  = {8'd0, m_q} << lsh;
               nv_d = 1'b0;
               nx_d = 1'b0;
            end else begin
               z_d  = {8'd0, m_q >> rsh};
               nv_d = 1'b0;
               nx_d = |(m_q & rmask);
            end
            state_d = PUT_Z;
         end
         PUT_Z: begin
            stb_d = 1'b1;
            if (output_z_stb && output_z_ack) begin
               stb_d   = 1'b0;
               state_d = GET_A;
            end
         end
         default: state_d = GET_A;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= GET_A;
         a_q       <= 32'd0;
         s_q       <= 1'b0;
         e_q       <= 10'sd0;
         m_q       <= 24'd0;
         e_max_q   <= 1'b0;
         e_zero_q  <= 1'b0;
         f_nz_q    <= 1'b0;
         spec_q    <= 1'b0;
         spec_z_q  <= 32'd0;
         spec_nv_q <= 1'b0;
         spec_nx_q <= 1'b0;
         z_q       <= 32'd0;
         nv_q      <= 1'b0;
         nx_q      <= 1'b0;
         stb_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         s_q       <= s_d;
         e_q       <= e_d;
         m_q       <= m_d;
         e_max_q   <= e_max_d;
         e_zero_q  <= e_zero_d;
         f_nz_q    <= f_nz_d;
         spec_q    <= spec_d;
         spec_z_q  <= spec_z_d;
         spec_nv_q <= spec_nv_d;
         spec_nx_q <= spec_nx_d;
         z_q       <= z_d;
         nv_q      <= nv_d;
         nx_q      <= nx_d;
         stb_q     <= stb_d;
      end
   end

endmodule

// File: tb/tb_float_to_unsig_int.sv
// Bench for float_to_unsig_int: scenario tasks with a result scoreboard.
module tb_float_to_unsig_int;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] input_a;
   logic        input_a_stb;
   logic        input_a_ack;
   logic [31:0] output_z;
   logic        output_z_stb;
   logic        output_z_ack;
   logic        output_nv;
   logic        output_nx;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [31:0] z;
      logic        nv;
      logic        nx;
   } exp_t;

   exp_t sb[$];

   float_to_unsig_int dut (
      .clk          (clk),
      .rst          (rst),
      .input_a      (input_a),
      .input_a_stb  (input_a_stb),
      .input_a_ack  (input_a_ack),
      .output_z     (output_z),
      .output_z_stb (output_z_stb),
      .output_z_ack (output_z_ack),
      .output_nv    (output_nv),
      .output_nx    (output_nx)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   // One conversion: push expectation, drive operand, check latency, stall, handshake.
   task automatic convert(input logic [31:0] a, input logic [31:0] ez, input logic env,
                          input logic enx, input int hold, input bit early_ack);
      int   n;
      bit   lat_ok;
      bit   stable;
      exp_t e;
      logic [31:0] z0;
      logic nv0, nx0;
      sb.push_back({ez, env, enx});
      @(negedge clk);
      input_a      = a;
      input_a_stb  = 1'b1;
      output_z_ack = early_ack;
      n = 0;
      while (input_a_ack !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (input_a_ack !== 1'b1) begin
         errors++;
         $display("FAIL accept a=%h: input_a_ack=%b, required 1", a, input_a_ack);
         input_a_stb = 1'b0;
         void'(sb.pop_back());
         return;
      end
      @(negedge clk);
      input_a_stb = 1'b0;
      input_a     = $urandom;
      lat_ok = 1'b1;
      for (int j = 0; j < 4; j++) begin
         if (j > 0) @(negedge clk);
         if (output_z_stb !== 1'b0 || input_a_ack !== 1'b0) lat_ok = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (!lat_ok || output_z_stb !== 1'b1) begin
         errors++;
         $display("FAIL latency a=%h: stb at E0+4=%b early_activity=%b, required stb 1 only at E0+4",
                  a, output_z_stb, !lat_ok);
      end
      if (output_z_stb !== 1'b1) begin
         void'(sb.pop_front());
         output_z_ack = 1'b0;
         return;
      end
      e = sb.pop_front();
      checks++;
      if ({output_z, output_nv, output_nx} !== e) begin
         errors++;
         $display("FAIL result a=%h: z=%h nv=%b nx=%b, required z=%h nv=%b nx=%b",
                  a, output_z, output_nv, output_nx, e.z, e.nv, e.nx);
      end
      if (hold > 0 && !early_ack) begin
         z0 = output_z; nv0 = output_nv; nx0 = output_nx;
         stable = 1'b1;
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (output_z_stb !== 1'b1 || input_a_ack !== 1'b0 || output_z !== z0 ||
                output_nv !== nv0 || output_nx !== nx0) stable = 1'b0;
         end
         checks++;
         if (!stable) begin
            errors++;
            $display("FAIL stall a=%h: stb=%b ack=%b z=%h, required stb 1 ack 0 z=%h held",
                     a, output_z_stb, input_a_ack, output_z, z0);
         end
      end
      output_z_ack = 1'b1;
      @(negedge clk);
      output_z_ack = 1'b0;
      checks++;
      if (output_z_stb !== 1'b0 || input_a_ack !== 1'b1 || output_z !== ez) begin
         errors++;
         $display("FAIL handshake a=%h: stb=%b ack=%b z=%h, required stb 0 ack 1 z=%h",
                  a, output_z_stb, input_a_ack, output_z, ez);
      end
   endtask

   task automatic test_reset();
      rst          = 1'b1;
      input_a      = 32'h4000_0000;
      input_a_stb  = 1'b1;
      output_z_ack = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (input_a_ack !== 1'b0 || output_z_stb !== 1'b0 || output_z !== 32'd0 ||
          output_nv !== 1'b0 || output_nx !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: ack=%b stb=%b z=%h nv=%b nx=%b, required all 0",
                  input_a_ack, output_z_stb, output_z, output_nv, output_nx);
      end
      input_a_stb = 1'b0;
      rst         = 1'b0;
      #1;
      checks++;
      if (input_a_ack !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_ack: ack=%b, required 1", input_a_ack);
      end
   endtask

   task automatic test_basic();
      convert(32'h4000_0000, 32'h0000_0002, 1'b0, 1'b0, 0, 1'b0);
      convert(32'h3F80_0000, 32'h0000_0001, 1'b0, 1'b0, 0, 1'b0);
      convert(32'h4049_0FDB, 32'h0000_0003, 1'b0, 1'b1, 0, 1'b0);
      convert(32'h4B00_0001, 32'h0080_0001, 1'b0, 1'b0, 0, 1'b0);
   endtask

   task automatic test_round_trip();
      convert(32'h4F7F_F000, 32'hFFF0_0000, 1'b0, 1'b0, 0, 1'b0);
      convert(32'h4F7F_FFFF, 32'hFFFF_FF00, 1'b0, 1'b0, 0, 1'b0);
      convert(32'h3FC0_0000, 32'h0000_0001, 1'b0, 1'b1, 0, 1'b0);
      convert(32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0, 1'b0, 0, 1'b0);
   endtask

   task automatic test_specials();
      convert(32'h4F80_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 0, 1'b0);
      convert(32'h7FC0_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 0, 1'b0);
      convert(32'hFFC0_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 0, 1'b0);
      convert(32'h7F80_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 0, 1'b0);
      convert(32'hFF80_0000, 32'h0000_0000, 1'b1, 1'b0, 0, 1'b0);
   endtask

   task automatic test_negatives_tiny();
      convert(32'hBF80_0000, 32'h0000_0000, 1'b1, 1'b0, 0, 1'b0);
      convert(32'hBF00_0000, 32'h0000_0000, 1'b0, 1'b1, 0, 1'b0);
      convert(32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0, 0, 1'b0);
      convert(32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1, 0, 1'b0);
      convert(32'h3F00_0000, 32'h0000_0000, 1'b0, 1'b1, 0, 1'b0);
   endtask

   task automatic test_backpressure();
      convert(32'h3FC0_0000, 32'h0000_0001, 1'b0, 1'b1, 5, 1'b0);
      convert(32'h4F80_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 3, 1'b0);
   endtask

   task automatic test_back_to_back();
      convert(32'h4120_0000, 32'h0000_000A, 1'b0, 1'b0, 0, 1'b1);
      convert(32'hBF00_0000, 32'h0000_0000, 1'b0, 1'b1, 0, 1'b1);
      convert(32'h4F00_0000, 32'h8000_0000, 1'b0, 1'b0, 0, 1'b1);
   endtask

   task automatic test_reset_midflight();
      int  n;
      bit  spurious;
      @(negedge clk);
      input_a     = 32'h4000_0000;
      input_a_stb = 1'b1;
      n = 0;
      while (input_a_ack !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      input_a_stb = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (input_a_ack !== 1'b0 || output_z_stb !== 1'b0 || output_z !== 32'd0 ||
          output_nv !== 1'b0 || output_nx !== 1'b0) begin
         errors++;
         $display("FAIL midflight_reset: ack=%b stb=%b z=%h nv=%b nx=%b, required all 0",
                  input_a_ack, output_z_stb, output_z, output_nv, output_nx);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (input_a_ack !== 1'b1) begin
         errors++;
         $display("FAIL midflight_ack: ack=%b, required 1", input_a_ack);
      end
      spurious = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (output_z_stb !== 1'b0) spurious = 1'b1;
      end
      checks++;
      if (spurious) begin
         errors++;
         $display("FAIL midflight_spurious_stb: stb seen=1, required 0");
      end
      convert(32'h4120_0000, 32'h0000_000A, 1'b0, 1'b0, 0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_round_trip();
      test_specials();
      test_negatives_tiny();
      test_backpressure();
      test_back_to_back();
      test_reset_midflight();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
